qracc_sram_arbiter: RTL and testbench

QRACC_SRAM_ARBITER -- requirements
Module: qracc_sram_arbiter

---
 rtl/qracc_sram_arbiter.sv | 159 +++++++++++++++
 tb/tb_qracc_sram_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/qracc_sram_arbiter.sv
// rtl/qracc_sram_arbiter.sv - two-requester round-robin arbiter in front of a single-port SRAM
// Optional read timeout enabled by defining QRACC_SRAM_ARB_TIMEOUT_EN.
module qracc_sram_arbiter #(
    parameter int numRows = 128,
    parameter int numCols = 32,
    localparam int AW = $clog2(numRows)
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               m0_rq_valid_i,
    input  logic               m0_rq_wr_i,
    input  logic [AW-1:0]      m0_addr_i,
    input  logic [numCols-1:0] m0_wr_data_i,
    output logic               m0_rq_ready_o,
    output logic               m0_rd_valid_o,
    output logic [numCols-1:0] m0_rd_data_o,

    input  logic               m1_rq_valid_i,
    input  logic               m1_rq_wr_i,
    input  logic [AW-1:0]      m1_addr_i,
    input  logic [numCols-1:0] m1_wr_data_i,
    output logic               m1_rq_ready_o,
    output logic               m1_rd_valid_o,
    output logic [numCols-1:0] m1_rd_data_o,

    output logic               sram_rq_valid_o,
    output logic               sram_rq_wr_o,
    output logic [AW-1:0]      sram_addr_o,
    output logic [numCols-1:0] sram_wr_data_o,
    input  logic               sram_rq_ready_i,
    input  logic               sram_rd_valid_i,
    input  logic [numCols-1:0] sram_rd_data_i,

    output logic               busy_o,
    output logic               owner_o,
    output logic               error_o
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RD} state_t;

    state_t               state, state_nx;
    logic                 rr_last;
    logic                 owner;
    logic                 hold_wr;
    logic [AW-1:0]        hold_addr;
    logic [numCols-1:0]   hold_data;
    logic                 grant_any;
    logic                 grant_id;
    logic                 rd_capture;
    logic                 timeout;
    logic                 rd_valid0, rd_valid1;
    logic [numCols-1:0]   rd_data0, rd_data1;

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = 1'b0;
        if (state == S_IDLE) begin
            if (m0_rq_valid_i && m1_rq_valid_i) begin
                grant_any = 1'b1;
                grant_id  = ~rr_last;
            end else if (m0_rq_valid_i) begin
                grant_any = 1'b1;
                grant_id  = 1'b0;
            end else if (m1_rq_valid_i) begin
                grant_any = 1'b1;
                grant_id  = 1'b1;
            end
        end
    end

    assign rd_capture = (state == S_WAIT_RD) && sram_rd_valid_i;

`ifdef QRACC_SRAM_ARB_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       error_q;

    // Count stays at zero outside S_WAIT_RD, so every wait starts fresh.
    assign timeout = (state == S_WAIT_RD) && !sram_rd_valid_i && (wait_cnt == 8'd254);

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 8'd0;
            error_q  <= 1'b0;
        end else begin
            if (state == S_WAIT_RD && !timeout && !sram_rd_valid_i)
                wait_cnt <= wait_cnt + 8'd1;
            else
                wait_cnt <= 8'd0;
            if (timeout)
                error_q <= 1'b1;
        end
    end

    assign error_o = error_q;
`else
    assign timeout = 1'b0;
    assign error_o = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (grant_any) state_nx = S_ISSUE;
            S_ISSUE:   if (sram_rq_ready_i) state_nx = hold_wr ? S_IDLE : S_WAIT_RD;
            S_WAIT_RD: if (rd_capture || timeout) state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rr_last   <= 1'b1;
            owner     <= 1'b0;
            hold_wr   <= 1'b0;
            hold_addr <= '0;
            hold_data <= '0;
            rd_valid0 <= 1'b0;
            rd_valid1 <= 1'b0;
            rd_data0  <= '0;
            rd_data1  <= '0;
        end else begin
            state     <= state_nx;
            rd_valid0 <= rd_capture && !owner;
            rd_valid1 <= rd_capture && owner;
            if (grant_any) begin
                rr_last   <= grant_id;
                owner     <= grant_id;
                hold_wr   <= grant_id ? m1_rq_wr_i   : m0_rq_wr_i;
                hold_addr <= grant_id ? m1_addr_i    : m0_addr_i;
                hold_data <= grant_id ? m1_wr_data_i : m0_wr_data_i;
            end
            if (rd_capture) begin
                if (owner)
                    rd_data1 <= sram_rd_data_i;
                else
                    rd_data0 <= sram_rd_data_i;
            end
        end
    end

    assign m0_rq_ready_o   = grant_any && !grant_id;
    assign m1_rq_ready_o   = grant_any && grant_id;
    assign m0_rd_valid_o   = rd_valid0;
    assign m1_rd_valid_o   = rd_valid1;
    assign m0_rd_data_o    = rd_data0;
    assign m1_rd_data_o    = rd_data1;

    assign sram_rq_valid_o = (state == S_ISSUE);
    assign sram_rq_wr_o    = (state == S_ISSUE) && hold_wr;
    assign sram_addr_o     = (state == S_ISSUE) ? hold_addr : '0;
    assign sram_wr_data_o  = (state == S_ISSUE) ? hold_data : '0;

    assign busy_o          = (state != S_IDLE);
    assign owner_o         = owner;

endmodule

// File: tb/tb_qracc_sram_arbiter.sv
// tb/tb_qracc_sram_arbiter.sv - directed self-checking bench for qracc_sram_arbiter
module tb_qracc_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_rq_valid_i, m0_rq_wr_i, m1_rq_valid_i, m1_rq_wr_i;
    logic [6:0]  m0_addr_i, m1_addr_i;
    logic [31:0] m0_wr_data_i, m1_wr_data_i;
    logic        m0_rq_ready_o, m0_rd_valid_o, m1_rq_ready_o, m1_rd_valid_o;
    logic [31:0] m0_rd_data_o, m1_rd_data_o;
    logic        sram_rq_valid_o, sram_rq_wr_o;
    logic [6:0]  sram_addr_o;
    logic [31:0] sram_wr_data_o;
    logic        sram_rq_ready_i, sram_rd_valid_i;
    logic [31:0] sram_rd_data_i;
    logic        busy_o, owner_o, error_o;

    int checks = 0;
    int failures = 0;

    // SRAM model: read latency 1, preloaded with 0xC0DE0000 | address on reset.
    logic [31:0] mem [0:127];
    logic        pend;
    logic [31:0] pend_data;
    logic        auto_rd = 1'b1;
    logic        force_rdv = 1'b0;
    logic        sram_ready = 1'b1;

    int          glog [16];
    int          rreq [16];
    int          rown [16];
    int          rcyc [16];
    logic [31:0] rdat [16];
    int          ng, nr;

    qracc_sram_arbiter #(.numRows(128), .numCols(32)) dut (
        .clk(clk), .rst(rst),
        .m0_rq_valid_i(m0_rq_valid_i), .m0_rq_wr_i(m0_rq_wr_i), .m0_addr_i(m0_addr_i),
        .m0_wr_data_i(m0_wr_data_i), .m0_rq_ready_o(m0_rq_ready_o),
        .m0_rd_valid_o(m0_rd_valid_o), .m0_rd_data_o(m0_rd_data_o),
        .m1_rq_valid_i(m1_rq_valid_i), .m1_rq_wr_i(m1_rq_wr_i), .m1_addr_i(m1_addr_i),
        .m1_wr_data_i(m1_wr_data_i), .m1_rq_ready_o(m1_rq_ready_o),
        .m1_rd_valid_o(m1_rd_valid_o), .m1_rd_data_o(m1_rd_data_o),
        .sram_rq_valid_o(sram_rq_valid_o), .sram_rq_wr_o(sram_rq_wr_o),
        .sram_addr_o(sram_addr_o), .sram_wr_data_o(sram_wr_data_o),
        .sram_rq_ready_i(sram_rq_ready_i), .sram_rd_valid_i(sram_rd_valid_i),
        .sram_rd_data_i(sram_rd_data_i),
        .busy_o(busy_o), .owner_o(owner_o), .error_o(error_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 128; i++) mem[i] <= 32'hC0DE0000 | 32'(i);
            pend      <= 1'b0;
            pend_data <= 32'h0;
        end else begin
            pend <= 1'b0;
            if (sram_rq_valid_o && sram_rq_ready_i) begin
                if (sram_rq_wr_o) begin
                    mem[sram_addr_o] <= sram_wr_data_o;
                end else begin
                    pend      <= auto_rd;
                    pend_data <= mem[sram_addr_o];
                end
            end
        end
    end

    assign sram_rq_ready_i = sram_ready;
    assign sram_rd_valid_i = pend | force_rdv;
    assign sram_rd_data_i  = force_rdv ? 32'hDEADBEEF : pend_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        m0_rq_valid_i = 1'b0; m0_rq_wr_i = 1'b0; m0_addr_i = 7'd0; m0_wr_data_i = 32'h0;
        m1_rq_valid_i = 1'b0; m1_rq_wr_i = 1'b0; m1_addr_i = 7'd0; m1_wr_data_i = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor loop: samples at each negedge, logs grants and read pulses, and
    // updates requester inputs one negedge after the grant (already latched).
    task automatic run(input int cycles, input int per_req);
        int  c0, c1;
        bit  g0, g1, d0, d1, i0, i1;
        c0 = 0; c1 = 0; ng = 0; nr = 0;
        for (int k = 0; k < cycles; k++) begin
            #1;
            g0 = m0_rq_ready_o; g1 = m1_rq_ready_o;
            d0 = 1'b0; d1 = 1'b0; i0 = 1'b0; i1 = 1'b0;
            if (m0_rd_valid_o && nr < 16) begin
                rreq[nr] = 0; rdat[nr] = m0_rd_data_o; rown[nr] = int'(owner_o); rcyc[nr] = k; nr++;
            end
            if (m1_rd_valid_o && nr < 16) begin
                rreq[nr] = 1; rdat[nr] = m1_rd_data_o; rown[nr] = int'(owner_o); rcyc[nr] = k; nr++;
            end
            if (g0 && ng < 16) begin
                glog[ng] = 0; ng++; c0++;
                if (c0 < per_req) i0 = 1'b1; else d0 = 1'b1;
            end
            if (g1 && ng < 16) begin
                glog[ng] = 1; ng++; c1++;
                if (c1 < per_req) i1 = 1'b1; else d1 = 1'b1;
            end
            @(negedge clk);
            if (d0) m0_rq_valid_i = 1'b0;
            if (d1) m1_rq_valid_i = 1'b0;
            if (i0) m0_addr_i = m0_addr_i + 7'd1;
            if (i1) m1_addr_i = m1_addr_i + 7'd1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        do_reset();

        // Reset state
        #1;
        check("rst_status", {busy_o, owner_o, error_o}, 3'b000);
        check("rst_ready", {m0_rq_ready_o, m1_rq_ready_o, m0_rd_valid_o, m1_rd_valid_o}, 4'b0000);
        check("rst_rd_data", {m0_rd_data_o, m1_rd_data_o}, 64'h0);
        check("rst_sram", {sram_rq_valid_o, sram_rq_wr_o, sram_addr_o, sram_wr_data_o}, 41'h0);

        // Single write from m0
        @(negedge clk);
        m0_rq_valid_i = 1'b1; m0_rq_wr_i = 1'b1; m0_addr_i = 7'd5; m0_wr_data_i = 32'hA5A5A5A5;
        #1;
        check("wr_c0_ready", {m0_rq_ready_o, m1_rq_ready_o}, 2'b10);
        @(negedge clk);
        m0_rq_valid_i = 1'b0;
        #1;
        check("wr_c1_sram", {sram_rq_valid_o, sram_rq_wr_o, sram_addr_o, sram_wr_data_o},
              {1'b1, 1'b1, 7'd5, 32'hA5A5A5A5});
        check("wr_c1_busy", {busy_o, m0_rq_ready_o}, 2'b10);
        @(negedge clk);
        #1;
        check("wr_c2_busy", busy_o, 1'b0);
        check("wr_mem", mem[5], 32'hA5A5A5A5);

        // Simultaneous reads from reset: m0 first, then m1
        do_reset();
        m0_rq_valid_i = 1'b1; m0_addr_i = 7'd3;
        m1_rq_valid_i = 1'b1; m1_addr_i = 7'd7;
        run(14, 1);
        check("both_ngrant", ng, 2);
        check("both_grant_order", {glog[0][0], glog[1][0]}, 2'b01);
        check("both_npulse", nr, 2);
        check("both_pulse0", {rreq[0][0], rown[0][0], rdat[0]}, {1'b0, 1'b0, 32'hC0DE0003});
        check("both_pulse1", {rreq[1][0], rown[1][0], rdat[1]}, {1'b1, 1'b1, 32'hC0DE0007});
        check("rd_latency", rcyc[0], 3);

        // Continuous contention: six alternating reads
        do_reset();
        m0_rq_valid_i = 1'b1; m0_addr_i = 7'd10;
        m1_rq_valid_i = 1'b1; m1_addr_i = 7'd20;
        run(24, 3);
        check("rr_ngrant", ng, 6);
        check("rr_npulse", nr, 6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("rr_grant%0d", i), glog[i], i % 2);
            check($sformatf("rr_pulse%0d", i), {rreq[i][0], rown[i][0], rdat[i]},
                  {1'(i % 2), 1'(i % 2),
                   (i % 2 == 1) ? 32'hC0DE0014 + 32'(i / 2) : 32'hC0DE000A + 32'(i / 2)});
        end

        // Reset while waiting for read data, then stale rd_valid from SRAM
        auto_rd = 1'b0;
        m0_rq_valid_i = 1'b1; m0_rq_wr_i = 1'b0; m0_addr_i = 7'd4;
        #1;
        check("abort_grant", m0_rq_ready_o, 1'b1);
        @(negedge clk);
        m0_rq_valid_i = 1'b0;
        @(negedge clk);
        #1;
        check("abort_in_wait", {busy_o, sram_rq_valid_o}, 2'b10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        force_rdv = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("abort_no_pulse", {m0_rd_valid_o, m1_rd_valid_o}, 2'b00);
            @(negedge clk);
            force_rdv = 1'b0;
        end
        #1;
        check("abort_status", {busy_o, owner_o, error_o, sram_rq_valid_o}, 4'b0000);
        check("abort_rd_data", {m0_rd_data_o, m1_rd_data_o}, 64'h0);

        // SRAM back-pressure for 10 cycles in S_ISSUE
        do_reset();
        auto_rd = 1'b1;
        sram_ready = 1'b0;
        m1_rq_valid_i = 1'b1; m1_rq_wr_i = 1'b1; m1_addr_i = 7'd9; m1_wr_data_i = 32'h12345678;
        #1;
        check("stall_grant", {m0_rq_ready_o, m1_rq_ready_o}, 2'b01);
        @(negedge clk);
        m1_rq_valid_i = 1'b0;
        m0_rq_valid_i = 1'b1; m0_rq_wr_i = 1'b0; m0_addr_i = 7'd2;
        for (int k = 0; k < 10; k++) begin
            #1;
            check($sformatf("stall_hold%0d", k),
                  {sram_rq_valid_o, sram_rq_wr_o, sram_addr_o, sram_wr_data_o, m0_rq_ready_o, m1_rq_ready_o},
                  {1'b1, 1'b1, 7'd9, 32'h12345678, 1'b0, 1'b0});
            @(negedge clk);
        end
        sram_ready = 1'b1;
        @(negedge clk);
        #1;
        check("stall_done_mem", mem[9], 32'h12345678);
        check("stall_next_grant", {m0_rq_ready_o, m1_rq_ready_o}, 2'b10);
        @(negedge clk);
        m0_rq_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("stall_next_read", {m0_rd_valid_o, m1_rd_valid_o, m0_rd_data_o}, {2'b10, 32'hC0DE0002});

        // Read whose data never arrives
        @(negedge clk);
        auto_rd = 1'b0;
        m1_rq_valid_i = 1'b1; m1_rq_wr_i = 1'b0; m1_addr_i = 7'd6;
        #1;
        check("tmo_grant", m1_rq_ready_o, 1'b1);
        @(negedge clk);
        m1_rq_valid_i = 1'b0;
        repeat (255) @(negedge clk);
        #1;
        check("tmo_before", {busy_o, error_o}, 2'b10);
        @(negedge clk);
`ifdef QRACC_SRAM_ARB_TIMEOUT_EN
        #1;
        check("tmo_fired", {busy_o, error_o, m1_rd_valid_o}, 3'b010);
        auto_rd = 1'b1;
        m0_rq_valid_i = 1'b1; m0_rq_wr_i = 1'b0; m0_addr_i = 7'd8;
        check("tmo_next_grant", m0_rq_ready_o, 1'b1);
        @(negedge clk);
        m0_rq_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("tmo_next_read", {m0_rd_valid_o, error_o, m0_rd_data_o}, {2'b11, 32'hC0DE0008});
`else
        #1;
        check("no_tmo_wait", {busy_o, error_o}, 2'b10);
        force_rdv = 1'b1;
        @(negedge clk);
        force_rdv = 1'b0;
        #1;
        check("no_tmo_done", {m1_rd_valid_o, m0_rd_valid_o, busy_o, m1_rd_data_o}, {3'b100, 32'hDEADBEEF});
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
